prn_reclaim_queue: RTL and testbench

// In-order reclaim buffer at the consumer end of the renamer's old-mapping output.
// - Captures, per renamed instruction, the superseded PRNs the renamer hands over.
// - Returns those PRNs to the renamer's free list once the instruction commits.
// - Commit is in program order, after completion.
// - Sits between rename (alloc side), execute writeback (complete side) and the free-list FIFO (free side).

---
 rtl/foxtrot_pkg.sv | 13 +
 rtl/prn_reclaim_queue.sv | 70 +++++++
 tb/tb_prn_reclaim_queue.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/foxtrot_pkg.sv
// foxtrot_pkg: shared rename/reclaim types and constants
package foxtrot_pkg;
  localparam int RQ_PRN_BITS = 6;
  localparam int RQ_MAX_OPS = 3;
  localparam int ARN_INVALID = 62;
  localparam int ARN_ZERO = 63;
  typedef enum logic [1:0] {RQ_FREE, RQ_PENDING, RQ_DONE} reclaim_state_t;
  typedef struct packed {
    reclaim_state_t state;
    logic [RQ_MAX_OPS-1:0] old_valid;
    logic [RQ_MAX_OPS-1:0][RQ_PRN_BITS-1:0] old_prn;
  } reclaim_entry_t;
endpackage

// File: rtl/prn_reclaim_queue.sv
// prn_reclaim_queue: in-order buffer returning superseded PRNs to the free list at commit
module prn_reclaim_queue
  import foxtrot_pkg::*;
#(
  parameter int PRN_BITS = RQ_PRN_BITS,
  parameter int MAX_OPERANDS = RQ_MAX_OPS,
  parameter int DEPTH = 16,
  localparam int TW = $clog2(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   alloc_valid,
  input  logic [MAX_OPERANDS-1:0]                alloc_old_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  alloc_old_prn,
  output logic                                   alloc_ready,
  output logic [TW-1:0]                          alloc_tag,
  input  logic [MAX_OPERANDS-1:0]                complete_valid,
  input  logic [MAX_OPERANDS-1:0][TW-1:0]        complete_tag,
  output logic [MAX_OPERANDS-1:0]                free_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns,
  output logic                                   commit_valid,
  output logic [TW-1:0]                          commit_tag,
  output logic [TW:0]                            count
);
  logic [TW:0] head, tail;
  reclaim_entry_t ent [DEPTH];
  logic full, do_alloc, do_commit;
  logic [TW-1:0] head_idx, tail_idx;
  always_comb begin
    head_idx = head[TW-1:0];
    tail_idx = tail[TW-1:0];
    full = (head[TW] != tail[TW]) && (head_idx == tail_idx);
    alloc_ready = !full;
    alloc_tag = tail_idx;
    count = tail - head;
    do_alloc = alloc_valid && !full;
    do_commit = ent[head_idx].state == RQ_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '{state: RQ_FREE, default: '0};
      free_valid <= '0;
      free_prns <= '0;
      commit_valid <= 1'b0;
      commit_tag <= '0;
    end else begin
      assert (!(alloc_valid && full));
      commit_valid <= do_commit;
      commit_tag <= do_commit ? head_idx : '0;
      free_valid <= do_commit ? ent[head_idx].old_valid : '0;
      free_prns <= do_commit ? ent[head_idx].old_prn : '0;
      // only PENDING entries complete, so duplicate or stale tags are harmless
      for (int j = 0; j < MAX_OPERANDS; j++)
        if (complete_valid[j]) begin
          assert (ent[complete_tag[j]].state == RQ_PENDING);
          if (ent[complete_tag[j]].state == RQ_PENDING) ent[complete_tag[j]].state <= RQ_DONE;
        end
      if (do_commit) begin
        ent[head_idx].state <= RQ_FREE;
        head <= head + 1'b1;
      end
      if (do_alloc) begin
        ent[tail_idx] <= '{state: RQ_PENDING, old_valid: alloc_old_valid, old_prn: alloc_old_prn};
        tail <= tail + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prn_reclaim_queue.sv
// tb_prn_reclaim_queue: directed self-checking bench for prn_reclaim_queue
module tb_prn_reclaim_queue;
  logic clk = 1'b0;
  logic rst;
  logic alloc_valid;
  logic [2:0] alloc_old_valid;
  logic [2:0][5:0] alloc_old_prn;
  logic alloc_ready;
  logic [3:0] alloc_tag;
  logic [2:0] complete_valid;
  logic [2:0][3:0] complete_tag;
  logic [2:0] free_valid;
  logic [2:0][5:0] free_prns;
  logic commit_valid;
  logic [3:0] commit_tag;
  logic [4:0] count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  prn_reclaim_queue dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_old_valid(alloc_old_valid),
    .alloc_old_prn(alloc_old_prn), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag), .free_valid(free_valid),
    .free_prns(free_prns), .commit_valid(commit_valid), .commit_tag(commit_tag), .count(count)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    alloc_valid = 1'b0;
    alloc_old_valid = '0;
    alloc_old_prn = '0;
    complete_valid = '0;
    complete_tag = '0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic drive_alloc(input logic [2:0] v, input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2);
    alloc_valid = 1'b1;
    alloc_old_valid = v;
    alloc_old_prn = {p2, p1, p0};
  endtask
  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (count !== 5'd0 || alloc_ready !== 1'b1 || free_valid !== 3'b000 || free_prns !== '0 || commit_valid !== 1'b0 || commit_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset: count=%0d ready=%b fv=%b fp=%h cv=%b ct=%0d", count, alloc_ready, free_valid, free_prns, commit_valid, commit_tag);
    end
    rst = 1'b0;
  endtask
  task automatic test_basic();
    drive_alloc(3'b011, 6'd40, 6'd41, 6'd0);
    #1;
    checks++;
    if (alloc_tag !== 4'd0) begin errors++; $display("FAIL basic_tag: got %0d want 0", alloc_tag); end
    step();
    idle();
    checks++;
    if (count !== 5'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", count); end
    complete_valid = 3'b001;
    complete_tag[0] = 4'd0;
    step();
    idle();
    checks++;
    if (commit_valid !== 1'b0 || free_valid !== 3'b000) begin
      errors++; $display("FAIL basic_early: cv=%b fv=%b want 0 000", commit_valid, free_valid);
    end
    step();
    checks++;
    if (commit_valid !== 1'b1 || commit_tag !== 4'd0 || free_valid !== 3'b011 || free_prns[0] !== 6'd40 || free_prns[1] !== 6'd41 || count !== 5'd0) begin
      errors++;
      $display("FAIL basic_free: cv=%b ct=%0d fv=%b p0=%0d p1=%0d count=%0d want 1 0 011 40 41 0", commit_valid, commit_tag, free_valid, free_prns[0], free_prns[1], count);
    end
    step();
    checks++;
    if (commit_valid !== 1'b0 || free_valid !== 3'b000) begin
      errors++; $display("FAIL basic_pulse: cv=%b fv=%b want 0 000", commit_valid, free_valid);
    end
  endtask
  task automatic test_in_order();
    logic [3:0] order [3] = '{4'd2, 4'd1, 4'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(3'b001, 6'(10 + i), 6'd0, 6'd0);
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      complete_valid = 3'b010;
      complete_tag[1] = order[i];
      step();
      checks++;
      if (commit_valid !== 1'b0) begin errors++; $display("FAIL order_hold%0d: cv=%b want 0", i, commit_valid); end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (commit_valid !== 1'b1 || commit_tag !== 4'(i) || free_valid !== 3'b001 || free_prns[0] !== 6'(10 + i)) begin
        errors++;
        $display("FAIL order_commit%0d: cv=%b ct=%0d fv=%b p0=%0d want 1 %0d 001 %0d", i, commit_valid, commit_tag, free_valid, free_prns[0], i, 10 + i);
      end
    end
    step();
    checks++;
    if (commit_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL order_drain: cv=%b count=%0d want 0 0", commit_valid, count); end
  endtask
  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_alloc(3'b001, 6'(20 + i), 6'd0, 6'd0);
      step();
    end
    idle();
    checks++;
    if (alloc_ready !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL full: ready=%b count=%0d want 0 16", alloc_ready, count); end
    complete_valid = 3'b100;
    complete_tag[2] = 4'd0;
    step();
    idle();
    checks++;
    if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_hold: ready=%b want 0", alloc_ready); end
    step();
    checks++;
    if (commit_valid !== 1'b1 || commit_tag !== 4'd0 || free_prns[0] !== 6'd20 || count !== 5'd15 || alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
      errors++;
      $display("FAIL full_release: cv=%b ct=%0d p0=%0d count=%0d ready=%b tag=%0d want 1 0 20 15 1 0", commit_valid, commit_tag, free_prns[0], count, alloc_ready, alloc_tag);
    end
  endtask
  task automatic test_wrap();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [5:0] pa, pc;
      pa = 6'((i * 7 + 3) % 64);
      pc = 6'((i + 50) % 64);
      drive_alloc(3'b101, pa, 6'd0, pc);
      #1;
      checks++;
      if (alloc_tag !== 4'(i % 16)) begin errors++; bad++; $display("FAIL wrap_tag%0d: got %0d want %0d", i, alloc_tag, i % 16); end
      step();
      idle();
      complete_valid = 3'b001;
      complete_tag[0] = 4'(i % 16);
      step();
      idle();
      step();
      checks++;
      if (commit_valid !== 1'b1 || commit_tag !== 4'(i % 16) || free_valid !== 3'b101 || free_prns[0] !== pa || free_prns[2] !== pc || count !== 5'd0) begin
        errors++; bad++;
        $display("FAIL wrap_commit%0d: cv=%b ct=%0d fv=%b p0=%0d p2=%0d count=%0d want 1 %0d 101 %0d %0d 0", i, commit_valid, commit_tag, free_valid, free_prns[0], free_prns[2], count, i % 16, pa, pc);
      end
      if (bad > 4) break;
    end
  endtask
  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(3'b001, 6'(30 + i), 6'd0, 6'd0);
      step();
    end
    idle();
    complete_valid = 3'b010;
    complete_tag[1] = 4'd0;
    step();
    idle();
    drive_alloc(3'b000, 6'd0, 6'd0, 6'd0);
    complete_valid = 3'b101;
    complete_tag[0] = 4'd4;
    complete_tag[2] = 4'd4;
    #1;
    checks++;
    if (alloc_tag !== 4'd5) begin errors++; $display("FAIL same_tag: got %0d want 5", alloc_tag); end
    step();
    idle();
    checks++;
    if (commit_valid !== 1'b1 || commit_tag !== 4'd0 || free_prns[0] !== 6'd30 || count !== 5'd5) begin
      errors++; $display("FAIL same_commit: cv=%b ct=%0d p0=%0d count=%0d want 1 0 30 5", commit_valid, commit_tag, free_prns[0], count);
    end
    complete_valid = 3'b111;
    complete_tag = {4'd3, 4'd2, 4'd1};
    step();
    idle();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (commit_valid !== 1'b1 || commit_tag !== 4'(k) || free_prns[0] !== 6'(30 + k)) begin
        errors++; $display("FAIL same_drain%0d: cv=%b ct=%0d p0=%0d want 1 %0d %0d", k, commit_valid, commit_tag, free_prns[0], k, 30 + k);
      end
    end
    step();
    checks++;
    if (commit_valid !== 1'b0 || free_valid !== 3'b000 || count !== 5'd1) begin
      errors++; $display("FAIL same_empty_alloc: cv=%b fv=%b count=%0d want 0 000 1", commit_valid, free_valid, count);
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_alloc(3'b111, 6'(i), 6'(i + 8), 6'(i + 16));
      step();
    end
    idle();
    complete_valid = 3'b111;
    complete_tag = {4'd2, 4'd1, 4'd0};
    step();
    idle();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (count !== 5'd0 || free_valid !== 3'b000 || commit_valid !== 1'b0 || alloc_ready !== 1'b1 || free_prns !== '0) begin
      errors++; $display("FAIL midrst: count=%0d fv=%b cv=%b ready=%b want 0 000 0 1", count, free_valid, commit_valid, alloc_ready);
    end
    drive_alloc(3'b001, 6'd5, 6'd0, 6'd0);
    #1;
    checks++;
    if (alloc_tag !== 4'd0) begin errors++; $display("FAIL midrst_tag: got %0d want 0", alloc_tag); end
    step();
    idle();
    step();
    checks++;
    if (count !== 5'd1 || commit_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: count=%0d cv=%b want 1 0", count, commit_valid); end
  endtask
  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_in_order();
    test_full();
    test_wrap();
    test_same_cycle();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
